// File: rtl/step_cmd_if.sv
`default_nettype none
// ============================================================================
// Module      : step_cmd_if
// Description : Button inputs and step-command outputs of step_cmd_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface step_cmd_if;
    logic       btn_up;
    logic       btn_down;
    logic [2:0] choose;
    logic       up_level;
    logic       down_level;

    modport master (
        output btn_up,
        output btn_down,
        input  choose,
        input  up_level,
        input  down_level
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output choose,
        output up_level,
        output down_level
    );
endinterface
`default_nettype wire

// File: rtl/step_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_cmd_gen
// Description : Debounced up/down buttons to single-cycle, auto-repeating
//               step commands (001 = up, 100 = down) for the step counter.
// Revision    : 1.0 - initial release
// ============================================================================
module step_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10,
    parameter int TIMER_W         = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    step_cmd_if.slave  bus
);

    localparam logic [2:0]         C_CMD_UP      = 3'b001;
    localparam logic [2:0]         C_CMD_DOWN    = 3'b100;
    localparam logic [2:0]         C_CMD_NONE    = 3'b000;
    localparam bit                 C_REPEAT_EN   = (REPEAT_DELAY > 0);
    localparam logic [TIMER_W-1:0] C_DB_LAST     = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] C_DELAY_LAST  = TIMER_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TIMER_W-1:0] C_PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] raw_btn;
    logic [1:0] level;

    assign raw_btn = {bus.btn_down, bus.btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic               sync1_q;
            logic               sync2_q;
            logic               level_q;
            logic               level_d;
            logic [TIMER_W-1:0] db_cnt_q;
            logic [TIMER_W-1:0] db_cnt_d;

            // Level toggles once the synchronised value has disagreed for
            // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
            always_comb begin
                level_d  = level_q;
                db_cnt_d = '0;
                if (sync2_q != level_q) begin
                    if (db_cnt_q == C_DB_LAST) begin
                        level_d = ~level_q;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    level_q  <= 1'b0;
                    db_cnt_q <= '0;
                end else begin
                    sync1_q  <= raw_btn[gi];
                    sync2_q  <= sync1_q;
                    level_q  <= level_d;
                    db_cnt_q <= db_cnt_d;
                end
            end

            assign level[gi] = level_q;
        end
    endgenerate

    state_t             state_q;
    state_t             state_d;
    logic               dir_q;      // 0 = up, 1 = down
    logic               dir_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [2:0]         choose_q;
    logic [2:0]         choose_d;

    logic               held_level;
    logic               other_level;
    logic [2:0]         dir_cmd;

    assign held_level  = dir_q ? level[1] : level[0];
    assign other_level = dir_q ? level[0] : level[1];
    assign dir_cmd     = dir_q ? C_CMD_DOWN : C_CMD_UP;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        choose_d = C_CMD_NONE;
        case (state_q)
            ST_IDLE: begin
                if (level[0] && level[1]) begin
                    state_d = ST_LOCK;
                end else if (level[0]) begin
                    choose_d = C_CMD_UP;
                    dir_d    = 1'b0;
                    timer_d  = '0;
                    state_d  = ST_DELAY;
                end else if (level[1]) begin
                    choose_d = C_CMD_DOWN;
                    dir_d    = 1'b1;
                    timer_d  = '0;
                    state_d  = ST_DELAY;
                end
            end
            // Release and lock are tested before the timer so they win over
            // a repeat pulse falling due in the same cycle.
            ST_DELAY: begin
                if (!held_level) begin
                    state_d = ST_IDLE;
                end else if (other_level) begin
                    state_d = ST_LOCK;
                end else if (C_REPEAT_EN) begin
                    if (timer_q == C_DELAY_LAST) begin
                        choose_d = dir_cmd;
                        timer_d  = '0;
                        state_d  = ST_REPEAT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!held_level) begin
                    state_d = ST_IDLE;
                end else if (other_level) begin
                    state_d = ST_LOCK;
                end else if (timer_q == C_PERIOD_LAST) begin
                    choose_d = dir_cmd;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOCK: begin
                if (!level[0] && !level[1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            timer_q  <= '0;
            choose_q <= C_CMD_NONE;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
            choose_q <= choose_d;
        end
    end

    assign bus.choose     = choose_q;
    assign bus.up_level   = level[0];
    assign bus.down_level = level[1];

endmodule
`default_nettype wire

// File: tb/tb_step_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_cmd_gen
// Description : Directed bench for step_cmd_gen (DEBOUNCE=4, DELAY=8, PERIOD=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_cmd_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    step_cmd_if bus ();

    step_cmd_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3),
        .TIMER_W         (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         base  = 0;
    int         up_cnt;
    int         dn_cnt;
    int         pulse_t[$];
    logic [2:0] pulse_v[$];
    int         exp_t[$];

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, logging pulses relative to the last mark.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.choose !== 3'b000) begin
                check("choose_legal", int'(bus.choose == 3'b001 || bus.choose == 3'b100), 1);
                pulse_t.push_back(cyc - base);
                pulse_v.push_back(bus.choose);
            end
            if (bus.up_level)   up_cnt++;
            if (bus.down_level) dn_cnt++;
        end
    endtask

    task automatic mark();
        base = cyc;
        pulse_t.delete();
        pulse_v.delete();
        up_cnt = 0;
        dn_cnt = 0;
    endtask

    task automatic expect_pulses(input string tag, input int val);
        check({tag, "_count"}, pulse_t.size(), exp_t.size());
        for (int i = 0; i < exp_t.size() && i < pulse_t.size(); i++) begin
            check($sformatf("%s_time%0d", tag, i), pulse_t[i], exp_t[i]);
            check($sformatf("%s_val%0d", tag, i), int'(pulse_v[i]), val);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        mark();
        step(3);
        check("rst_choose", int'(bus.choose), 0);
        check("rst_up_level", int'(bus.up_level), 0);
        check("rst_down_level", int'(bus.down_level), 0);
        rst = 1'b0;
        step(5);

        // Short press: one up pulse 2+4+1 cycles after the raw edge.
        mark();
        bus.btn_up = 1'b1;
        step(6);
        bus.btn_up = 1'b0;
        step(20);
        exp_t = '{7};
        expect_pulses("short_up", 1);
        check("short_up_level_cycles", up_cnt, 6);

        // Long down hold: T, T+8, then every 3 until the debounced release.
        mark();
        bus.btn_down = 1'b1;
        step(30);
        bus.btn_down = 1'b0;
        step(30);
        exp_t = '{7, 15, 18, 21, 24, 27, 30, 33, 36};
        expect_pulses("hold_down", 4);
        check("hold_down_level_cycles", dn_cnt, 30);

        // Bouncing input never survives debounce.
        mark();
        for (int k = 0; k < 5; k++) begin
            bus.btn_up = 1'b1;
            step(2);
            bus.btn_up = 1'b0;
            step(2);
        end
        step(10);
        exp_t.delete();
        expect_pulses("bounce", 0);
        check("bounce_level_cycles", up_cnt, 0);

        // Down level joins at T+5 while up held: lock before the first repeat.
        mark();
        bus.btn_up = 1'b1;
        step(6);
        bus.btn_down = 1'b1;
        step(20);
        exp_t = '{7};
        expect_pulses("lock_first", 1);
        mark();
        bus.btn_down = 1'b0;
        step(20);
        bus.btn_up = 1'b0;
        step(15);
        exp_t.delete();
        expect_pulses("lock_release", 0);
        mark();
        bus.btn_down = 1'b1;
        step(6);
        bus.btn_down = 1'b0;
        step(20);
        exp_t = '{7};
        expect_pulses("after_lock_down", 4);

        // Simultaneous press locks with no pulse; next single press is normal.
        mark();
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        step(10);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        step(20);
        exp_t.delete();
        expect_pulses("both_press", 0);
        mark();
        bus.btn_up = 1'b1;
        step(6);
        bus.btn_up = 1'b0;
        step(20);
        exp_t = '{7};
        expect_pulses("after_both_up", 1);
        check("after_both_up_level_cycles", up_cnt, 6);

        // Reset mid-repeat clears outputs without waiting for a clock edge.
        mark();
        bus.btn_up = 1'b1;
        step(21);
        exp_t = '{7, 15, 18, 21};
        expect_pulses("pre_rst", 1);
        check("pre_rst_choose", int'(bus.choose), 1);
        rst = 1'b1;
        #1;
        check("async_rst_choose", int'(bus.choose), 0);
        check("async_rst_up_level", int'(bus.up_level), 0);
        check("async_rst_down_level", int'(bus.down_level), 0);
        step(3);
        rst = 1'b0;
        mark();
        step(19);
        exp_t = '{7, 15, 18};
        expect_pulses("post_rst", 1);
        bus.btn_up = 1'b0;
        step(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_cmd_gen.md
Name: step_cmd_gen

Overview:
- Produces the 3-bit step command bus that drives the 3-bit up/down step counter.
- Takes raw up/down push-buttons and synchronises and debounces each one.
- Converts each debounced press into a single-cycle command pulse: 3'b001 = step up, 3'b100 = step down.
- While a button is held, it auto-repeats the pulse. Sits between the board button pins and the counter's choose input, on the same clock.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive cycles a synchronised button value must differ from the accepted level before the level changes (>=1).
- REPEAT_DELAY, 50: cycles from the first pulse to the first auto-repeat pulse. 0 disables auto-repeat.
- REPEAT_PERIOD, 10: cycles between successive auto-repeat pulses (>=1).
- TIMER_W, 16: width of the debounce and repeat timers. Must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- btn_up  input  1  raw up button, asynchronous, active-high
- btn_down  input  1  raw down button, asynchronous, active-high
- choose  output  3  step command: 3'b001 up pulse, 3'b100 down pulse, else 3'b000
- up_level  output  1  debounced up level
- down_level  output  1  debounced down level

Behaviour:
- Reset (async assert, sync release):
  - choose=3'b000, up_level=0, down_level=0.
  - Synchronisers=0, all timers=0, FSM=IDLE.
  - A button held through reset release counts as a new press after debounce.
- Synchronisation: two-flop synchroniser per button. The sync value follows the raw input 2 rising edges later.
- Debounce, per button, independent:
  - If sync value == accepted level, the timer clears.
  - Otherwise the timer increments. When it reaches DEBOUNCE_CYCLES, the level toggles and the timer clears.
  - Any single-cycle glitch shorter than DEBOUNCE_CYCLES never changes the level.
- choose legality:
  - Registered output. Only ever 000, 001 or 100; never 010, 011, 101, 110 or 111.
  - Each non-zero value lasts exactly one cycle.
- FSM states: IDLE, DELAY, REPEAT, LOCK. A dir register records up or down.
- IDLE:
  - Up level rises with down level low: choose=001 next cycle, dir=up, timer=0, go to DELAY.
  - Down rise (up low) is symmetric, giving 100.
  - Both levels high in the same cycle: go to LOCK, no pulse.
- DELAY:
  - Held dir level falls: go to IDLE, no pulse.
  - Opposite level rises: go to LOCK.
  - Timer reaches REPEAT_DELAY-1: emit pulse for dir, timer=0, go to REPEAT.
  - If REPEAT_DELAY=0, stay in DELAY until release or lock.
- REPEAT: same release and lock rules as DELAY. Timer reaches REPEAT_PERIOD-1: emit pulse, timer=0.
- LOCK: choose=000. Go to IDLE only when both levels are 0.
- Pulse timing with the button held and first pulse at cycle T: second pulse at T+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- Release and lock take priority over a repeat pulse due in the same cycle.
- Latency: raw rising edge, stable, to choose non-zero is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Release behaviour: the debounced release is followed by no pulse. A new press is accepted only from IDLE.
- Timer arithmetic: unsigned TIMER_W bits. Timers never wrap in normal use because the compare resets them.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Reset, then btn_up high for 6 cycles and low → exactly one choose=001 pulse, 7 cycles after the raw edge; up_level high for 6 cycles; no repeats.
- btn_down held 30 cycles → 100 at T, T+8, T+11, T+14, …, stopping after down_level falls. Pulse count matches the hold length; no 001 ever.
- btn_up toggling every 2 cycles for 20 cycles, then low → up_level stays 0, choose stays 000 throughout.
- Hold btn_up; at T+5 also press btn_down → one 001 at T, LOCK, no further pulses. Release down only: still none. Release both, press down: single 100.
- Both buttons rise in the same cycle → choose 000 until both are released; the next single press behaves normally.
- Assert rst mid-REPEAT with btn_up held → outputs 0 immediately (asynchronous). After release: new 001 after 2+4+1 cycles, then repeats at +8 and +3.
